// File: rtl/pipelined_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_chunk_adder
// Purpose  : WIDTH-bit add/subtract split into CHUNK-bit ripple segments, one
//            segment per pipeline stage, carries registered between stages.
//            valid/ready handshake on both sides with full backpressure.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            in_valid   - operation offered
//            in_ready   - block can accept (combinational)
//            a, b       - operands, WIDTH bits
//            cin        - carry-in for add (ignored for subtract)
//            sub        - 0: a+b+cin, 1: a-b
//            out_valid  - result presented
//            out_ready  - consumer accepts result
//            sum        - result, WIDTH bits
//            cout       - carry out of MSB (1 = no borrow for subtract)
//            ovf        - two's-complement overflow
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_chunk_adder #(
  parameter int WIDTH = 11,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST   = WIDTH - (STAGES - 1) * CHUNK;
  localparam int LS     = STAGES - 1;

  // Per-stage inputs (from ports for stage 0, from the previous stage's
  // registers otherwise) and per-stage registered state.
  logic             w_vin  [STAGES];
  logic             w_cin  [STAGES];
  logic [WIDTH-1:0] w_opa  [STAGES];
  logic [WIDTH-1:0] w_opb  [STAGES];
  logic [WIDTH-1:0] w_prev [STAGES];
  logic [CHUNK:0]   w_add  [STAGES];
  logic [WIDTH-1:0] w_psum [STAGES];

  logic             r_v    [STAGES];
  logic             r_c    [STAGES];
  logic [WIDTH-1:0] r_opa  [STAGES];
  logic [WIDTH-1:0] r_opb  [STAGES];
  logic [WIDTH-1:0] r_sum  [STAGES];
  logic             r_ovf;

  logic             w_adv;
  logic             w_ovf;

  // The whole pipeline moves as one: it only stops when a result is being
  // presented and the consumer refuses it.
  assign w_adv    = !r_v[LS] || out_ready;
  // Reset discards everything in flight, so inputs are never blocked then.
  assign in_ready = w_adv || rst;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int CW = (i == STAGES - 1) ? LAST : CHUNK;

    if (i == 0) begin : g_src_port
      assign w_vin[i]  = in_valid;
      assign w_cin[i]  = sub | cin;
      assign w_opa[i]  = a;
      assign w_opb[i]  = sub ? ~b : b;
      assign w_prev[i] = '0;
    end else begin : g_src_reg
      assign w_vin[i]  = r_v[i-1];
      assign w_cin[i]  = r_c[i-1];
      assign w_opa[i]  = r_opa[i-1];
      assign w_opb[i]  = r_opb[i-1];
      assign w_prev[i] = r_sum[i-1];
    end

    // Operands are kept right-aligned: the active chunk is always the low
    // CHUNK bits. Zeros shifted in above the MSB mean that in a short last
    // chunk the carry out of bit WIDTH-1 lands in sum bit CW of the adder.
    assign w_add[i]  = {1'b0, w_opa[i][CHUNK-1:0]}
                     + {1'b0, w_opb[i][CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, w_cin[i]};
    // Bits above the already-computed chunks are still zero, so OR inserts.
    assign w_psum[i] = w_prev[i] | (WIDTH'(w_add[i][CW-1:0]) << (i * CHUNK));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v[i]   <= 1'b0;
        r_c[i]   <= 1'b0;
        r_sum[i] <= '0;
      end else if (w_adv) begin
        r_v[i] <= w_vin[i];
        // Data only updates for real operations, so idle outputs stay quiet.
        if (w_vin[i]) begin
          r_c[i]   <= w_add[i][CW];
          r_sum[i] <= w_psum[i];
          r_opa[i] <= w_opa[i] >> CHUNK;
          r_opb[i] <= w_opb[i] >> CHUNK;
        end
      end
    end
  end

  // Carry into the MSB recovered as a^b^s at that bit, XORed with carry out.
  assign w_ovf = w_opa[LS][LAST-1] ^ w_opb[LS][LAST-1]
               ^ w_add[LS][LAST-1] ^ w_add[LS][LAST];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv && w_vin[LS]) begin
      r_ovf <= w_ovf;
    end
  end

  assign out_valid = r_v[LS];
  assign sum       = r_sum[LS];
  assign cout      = r_c[LS];
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_chunk_adder
// Purpose  : Self-checking bench for pipelined_chunk_adder. Four instances
//            with different (WIDTH, CHUNK); instance 0 also runs directed
//            cases. Scoreboard queue per instance, arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_chunk_adder;

  localparam int NCFG = 4;
  localparam int CFG_W [NCFG] = '{11, 11, 16, 8};
  localparam int CFG_C [NCFG] = '{4, 11, 5, 1};
  localparam int NRAND = 600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   n_done   = 0;
  bit   go_rand  = 1'b0;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = CFG_W[g];
    localparam int C  = CFG_C[g];
    localparam int ST = (W + C - 1) / C;

    typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
    } exp_t;

    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    exp_t         q[$];
    exp_t         e;
    int           n_out = 0;

    pipelined_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    // Reference: unsigned result for sum/cout, signed result for overflow.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                   input logic tc, input logic ts);
      longint m  = longint'(1) << W;
      longint ua = longint'(ta);
      longint ub = longint'(tbv);
      longint sa = (ua >= m / 2) ? ua - m : ua;
      longint sb = (ub >= m / 2) ? ub - m : ub;
      longint r, sr;
      exp_t   x;
      r    = ts ? (ua - ub + m) : (ua + ub + longint'(tc));
      sr   = ts ? (sa - sb) : (sa + sb + longint'(tc));
      x.s  = r[W-1:0];
      x.c  = (r >= m);
      x.o  = (sr >= m / 2) || (sr < -(m / 2));
      return x;
    endfunction

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 3))
        0:       return '0;
        1:       return '1;
        2:       return {1'b0, {(W-1){1'b1}}};
        default: return W'($urandom);
      endcase
    endfunction

    // Scoreboard: push on input transfer, pop/compare on output transfer.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          n_out++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL cfg%0d unexpected_output: got sum=%0h cout=%0b ovf=%0b required none",
                     g, sum, cout, ovf);
          end else begin
            e = q.pop_front();
            if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
              failures++;
              $display("FAIL cfg%0d result: got sum=%0h cout=%0b ovf=%0b required sum=%0h cout=%0b ovf=%0b",
                       g, sum, cout, ovf, e.s, e.c, e.o);
            end
          end
        end
        if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      end
    end

    task automatic rand_phase();
      for (int i = 0; i < NRAND; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        a         = pick();
        b         = pick();
        cin       = 1'($urandom);
        sub       = 1'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (ST + 2) tick();
      check($sformatf("cfg%0d_drained", g), q.size(), 0);
      check($sformatf("cfg%0d_had_outputs", g), longint'(n_out > 0), 1);
      n_done++;
    endtask

    if (g == 0) begin : g_dir
      task automatic op(input int ta, input int tbv, input bit tc, input bit ts);
        in_valid = 1'b1;
        a        = W'(ta);
        b        = W'(tbv);
        cin      = tc;
        sub      = ts;
      endtask

      task automatic expect_out(input string name, input int s, input bit c, input bit o);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_sum"}, sum, s);
        check({name, "_cout"}, cout, c);
        check({name, "_ovf"}, ovf, o);
      endtask

      initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Carry ripples through all chunks; latency is STAGES edges.
        op('h7FF, 'h001, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        check("lat_edge1", out_valid, 0); tick();
        check("lat_edge2", out_valid, 0); tick();
        expect_out("carry_all", 'h000, 1'b1, 1'b0);

        // Signed overflow, then subtract with borrow.
        op('h3FF, 'h001, 1'b0, 1'b0); tick();
        op('h005, 'h007, 1'b0, 1'b1); tick();
        in_valid = 1'b0; tick();
        expect_out("ovf_add", 'h400, 1'b0, 1'b1); tick();
        expect_out("sub_borrow", 'h7FE, 1'b0, 1'b0); tick();

        // Streaming with no stall.
        op(1, 2, 1'b0, 1'b0); tick();
        op(3, 4, 1'b0, 1'b0); tick();
        op(5, 6, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        expect_out("stream0", 3, 1'b0, 1'b0); tick();
        expect_out("stream1", 7, 1'b0, 1'b0); tick();
        expect_out("stream2", 11, 1'b0, 1'b0); tick();
        check("stream_idle", out_valid, 0);

        // Streaming with a two-cycle stall while a fourth op is offered.
        op(1, 2, 1'b0, 1'b0); tick();
        op(3, 4, 1'b0, 1'b0); tick();
        op(5, 6, 1'b0, 1'b0); tick();
        op(7, 8, 1'b0, 1'b0);
        out_ready = 1'b0; #1;
        check("stall0_in_ready", in_ready, 0);
        expect_out("stall0", 3, 1'b0, 1'b0); tick();
        check("stall1_in_ready", in_ready, 0);
        expect_out("stall1", 3, 1'b0, 1'b0); tick();
        check("stall2_in_ready", in_ready, 0);
        expect_out("stall2", 3, 1'b0, 1'b0);
        out_ready = 1'b1; #1;
        check("unstall_in_ready", in_ready, 1); tick();
        in_valid = 1'b0;
        expect_out("after_stall1", 7, 1'b0, 1'b0); tick();
        expect_out("after_stall2", 11, 1'b0, 1'b0); tick();
        expect_out("after_stall3", 15, 1'b0, 1'b0); tick();
        check("after_stall_idle", out_valid, 0);

        // Reset drops in-flight operations.
        op('h010, 'h020, 1'b0, 1'b0); tick();
        op('h030, 'h040, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0;
        check("drop_valid0", out_valid, 0);
        check("drop_sum0", sum, 0);
        op('h001, 'h001, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        check("drop_valid1", out_valid, 0); tick();
        check("drop_valid2", out_valid, 0); tick();
        expect_out("post_rst", 'h002, 1'b0, 1'b0); tick();

        go_rand = 1'b1;
        rand_phase();
      end
    end else begin : g_wait
      initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        wait (go_rand);
        tick();
        rand_phase();
      end
    end
  end

  initial begin
    for (int c = 0; c < 20000 && n_done < NCFG; c++) @(posedge clk);
    if (n_done < NCFG) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d finished configs required %0d", n_done, NCFG);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_chunk_adder.md
# pipelined_chunk_adder

Parametrised, pipelined successor to the fixed-width 11-bit ripple-carry adder. It splits a WIDTH-bit add or subtract into CHUNK-bit ripple segments, one segment per pipeline stage, with carries registered between stages. The block accepts one operation per cycle under a valid/ready handshake with full backpressure. It serves as the mantissa/exponent adder in the FP16 MAC datapath, where a full-width combinational ripple does not meet timing.

## Interface
Parameters:
- WIDTH, 11, operand and result width in bits (≥ 2).
- CHUNK, 4, bits added per pipeline stage (1..WIDTH).
- STAGES (derived, not overridable), ceil(WIDTH/CHUNK), pipeline depth. The last chunk holds WIDTH − (STAGES−1)·CHUNK bits.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, operation offered.
- in_ready, out, 1, block can accept; transfer happens when in_valid && in_ready.
- a, in, WIDTH, operand A.
- b, in, WIDTH, operand B.
- cin, in, 1, carry-in; ignored when sub=1.
- sub, in, 1, 0: a+b+cin; 1: a+~b+1, i.e. a−b.
- out_valid, out, 1, result presented.
- out_ready, in, 1, consumer accepts; transfer happens when out_valid && out_ready.
- sum, out, WIDTH, result bits.
- cout, out, 1, carry out of the MSB. For sub, 1 means no borrow.
- ovf, out, 1, two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational.
- When adv=0, every stage register holds its value, including valid bits.
- Stage 0, on an accepted transfer, registers:
  - bits [CHUNK−1:0] of the sum;
  - the chunk carry-out;
  - the unconsumed upper bits of a and of b (b already inverted when sub=1);
  - a valid bit.
- Stage 0 carry-in is cin when sub=0 and 1 when sub=1.
- Stage i (1..STAGES−1), on adv:
  - adds chunk i of the delayed operands plus the registered carry from stage i−1;
  - appends the result to the partial sum;
  - shifts its valid bit forward.
- The last stage also registers ovf from the carries into and out of bit WIDTH−1.
- sum, cout, ovf and out_valid come directly from last-stage registers; no combinational path runs from a/b to sum.
- Bubbles (in_valid=0 while adv=1) propagate as valid=0 entries.
- When STAGES=1 the block degenerates to a single registered adder. The handshake rules are unchanged.
- Reset: all valid bits clear. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 during and after reset. Operations in flight when reset asserts are discarded and produce no output.

## Timing
- Latency: an operation accepted at edge k appears with out_valid=1 after edge k+STAGES−1, provided no stall occurs. It is therefore visible in the cycle after STAGES accepting edges.
- Throughput: one operation per cycle while out_ready=1.
- A stall freezes the pipeline for exactly as long as out_valid && !out_ready holds.
- While stalled, sum, cout and ovf are stable and in_ready=0.
- Results leave in acceptance order. None are lost or duplicated.
- A simultaneous output transfer and input acceptance in the same cycle is legal and is the normal streaming case.
- Reset wins over any simultaneous handshake.

## Test plan
All cases use WIDTH=11, CHUNK=4, STAGES=3 unless stated otherwise.
- a=0x7FF, b=0x001, cin=0, sub=0 → sum=0x000, cout=1, ovf=0, out_valid high 3 cycles after acceptance. This checks carry propagation across all chunks.
- a=0x3FF, b=0x001, sub=0 → sum=0x400, cout=0, ovf=1. Then a=0x005, b=0x007, sub=1 → sum=0x7FE, cout=0, ovf=0.
- Stream vectors (1,2), (3,4), (5,6) on consecutive cycles with out_ready=1 → sums 3, 7, 11 on three consecutive cycles. Repeat with out_ready low for 2 cycles mid-stream → in_ready low for those cycles, outputs held stable, same order, no loss.
- Assert rst one cycle after accepting two operations → out_valid stays 0 and both operations are dropped. The next operation, a=0x001, b=0x001, yields sum=0x002 after 3 cycles.
- Random constrained traffic with random in_valid/out_ready against a reference model (a + (sub ? ~b+1 : b+cin)), for (WIDTH, CHUNK) = (11,4), (11,11), (16,5), (8,1) → all results, cout and ovf match, and results arrive in order.
